// File: rtl/wb_select_stage.sv
// Write-back stage: M/W pipeline register with stall/flush, sub-word load
// extraction and write-back source select driving the register-file port.

module wb_load_ext #(
  parameter int DATA_W = 32
) (
  input  logic [31:0]       word,
  input  logic [1:0]        off,
  input  logic [2:0]        ldop,
  output logic [DATA_W-1:0] data
);
  logic [3:0][7:0] lanes;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;

  assign lanes    = word;
  assign byte_sel = lanes[off];
  // halfword picks on alu[1] only; a misaligned lh is not trapped here
  assign half_sel = off[1] ? word[31:16] : word[15:0];

  always_comb begin
    data = DATA_W'($signed(word));
    case (ldop)
      3'd1:    data = DATA_W'($signed(half_sel));
      3'd2:    data = DATA_W'(half_sel);
      3'd3:    data = DATA_W'($signed(byte_sel));
      3'd4:    data = DATA_W'(byte_sel);
      default: data = DATA_W'($signed(word));
    endcase
  end
endmodule

module wb_select_stage #(
  parameter int DATA_W = 32,
  parameter int RA_W   = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  input  logic              flush,
  input  logic [DATA_W-1:0] m_pc,
  input  logic [2:0]        m_wbop,
  input  logic [2:0]        m_ldop,
  input  logic [DATA_W-1:0] m_alu,
  input  logic [DATA_W-1:0] m_dm,
  input  logic [DATA_W-1:0] m_imm,
  input  logic [DATA_W-1:0] m_md,
  input  logic [RA_W-1:0]   m_rd,
  input  logic              m_we,
  output logic [DATA_W-1:0] w_pc,
  output logic [DATA_W-1:0] w_data,
  output logic [RA_W-1:0]   w_rd,
  output logic              w_we
);
  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [2:0]        wbop;
    logic [2:0]        ldop;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] dm;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] md;
    logic [RA_W-1:0]   rd;
    logic              we;
  } mw_t;

  mw_t               m_bus;
  mw_t               w_q;
  logic [DATA_W-1:0] ld_data;

  // writes to $0 are dropped at capture so they never forward either
  always_comb begin
    m_bus      = '0;
    m_bus.pc   = m_pc;
    m_bus.wbop = m_wbop;
    m_bus.ldop = m_ldop;
    m_bus.alu  = m_alu;
    m_bus.dm   = m_dm;
    m_bus.imm  = m_imm;
    m_bus.md   = m_md;
    m_bus.rd   = m_rd;
    m_bus.we   = m_we && (m_rd != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset)     w_q <= '0;
    else if (flush) w_q <= '0;
    else if (en)    w_q <= m_bus;
  end

  wb_load_ext #(.DATA_W(DATA_W)) u_ld (
    .word (w_q.dm[31:0]),
    .off  (w_q.alu[1:0]),
    .ldop (w_q.ldop),
    .data (ld_data)
  );

  generate
    if (DATA_W > 32) begin : g_wide
      logic unused_dm_hi;
      assign unused_dm_hi = ^w_q.dm[DATA_W-1:32];
    end
  endgenerate

  always_comb begin
    w_data = '0;
    case (w_q.wbop)
      3'd0:    w_data = w_q.alu;
      3'd1:    w_data = ld_data;
      3'd2:    w_data = w_q.imm;
      3'd3:    w_data = w_q.pc + DATA_W'(8);
      3'd4:    w_data = w_q.md;
      default: w_data = '0;
    endcase
  end

  assign w_pc = w_q.pc;
  assign w_rd = w_q.rd;
  assign w_we = w_q.we && (w_q.wbop <= 3'd4);
endmodule

// File: tb/tb_wb_select_stage.sv
// Randomized + directed bench for wb_select_stage against an arithmetic model;
// a second 64-bit instance covers the wide-datapath extension and pc wrap.

module tb_wb_select_stage;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset, en, flush;
  logic [31:0] pc, alu, dm, imm, md;
  logic [2:0]  wbop, ldop;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] w_pc, w_data;
  logic [4:0]  w_rd;
  logic        w_we;

  logic [63:0] pc64, alu64, dm64, imm64, md64;
  logic [2:0]  wbop64, ldop64;
  logic [4:0]  rd64;
  logic        we64;
  logic [63:0] w_pc64, w_data64;
  logic [4:0]  w_rd64;
  logic        w_we64;

  wb_select_stage #(.DATA_W(32), .RA_W(5)) dut (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .m_pc(pc), .m_wbop(wbop), .m_ldop(ldop), .m_alu(alu), .m_dm(dm),
    .m_imm(imm), .m_md(md), .m_rd(rd), .m_we(we),
    .w_pc(w_pc), .w_data(w_data), .w_rd(w_rd), .w_we(w_we));

  wb_select_stage #(.DATA_W(64), .RA_W(5)) dut64 (
    .clk(clk), .reset(reset), .en(en), .flush(flush),
    .m_pc(pc64), .m_wbop(wbop64), .m_ldop(ldop64), .m_alu(alu64), .m_dm(dm64),
    .m_imm(imm64), .m_md(md64), .m_rd(rd64), .m_we(we64),
    .w_pc(w_pc64), .w_data(w_data64), .w_rd(w_rd64), .w_we(w_we64));

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] e_pc, e_data;
  logic [4:0]  e_rd;
  logic        e_we;

  // Reference result computed from the source/load rules with plain arithmetic.
  function automatic logic [63:0] ref_data(int w, logic [2:0] op, logic [2:0] lop,
      logic [63:0] p, logic [63:0] a, logic [63:0] d, logic [63:0] i, logic [63:0] m);
    logic [63:0] mask, word, b, h, r;
    int off;
    mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
    word = d & 64'hFFFF_FFFF;
    off  = int'(a % 4);
    b    = (word >> (8 * off)) & 64'hFF;
    h    = (word >> (16 * (off / 2))) & 64'hFFFF;
    case (op)
      3'd0: r = a;
      3'd1: case (lop)
              3'd1: r = (h >= 64'd32768) ? h - 64'd65536 : h;
              3'd2: r = h;
              3'd3: r = (b >= 64'd128) ? b - 64'd256 : b;
              3'd4: r = b;
              default: r = (word >= 64'h8000_0000) ? word - 64'h1_0000_0000 : word;
            endcase
      3'd2: r = i;
      3'd3: r = p + 64'd8;
      3'd4: r = m;
      default: r = 64'd0;
    endcase
    return r & mask;
  endfunction

  // Update the 32-bit expectation from the current inputs, then clock once.
  task automatic advance();
    logic [63:0] r;
    if (!reset || flush) begin
      e_pc = '0; e_data = '0; e_rd = '0; e_we = 1'b0;
    end else if (en) begin
      r      = ref_data(32, wbop, ldop, {32'd0, pc}, {32'd0, alu}, {32'd0, dm},
                        {32'd0, imm}, {32'd0, md});
      e_pc   = pc;
      e_data = r[31:0];
      e_rd   = rd;
      e_we   = we && (rd != 5'd0) && (wbop <= 3'd4);
    end
    @(posedge clk); #1;
  endtask

  task automatic randomize_m();
    pc = $urandom; alu = $urandom; dm = $urandom; imm = $urandom; md = $urandom;
    wbop = 3'($urandom_range(0, 7)); ldop = 3'($urandom_range(0, 7));
    rd = 5'($urandom_range(0, 31)); we = 1'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; en = 1'b1; flush = 1'b0;
    repeat (2) begin randomize_m(); advance(); end
    n_checks++;
    if ({w_pc, w_data, w_rd, w_we} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got pc=%h data=%h rd=%0d we=%b, want all 0",
               w_pc, w_data, w_rd, w_we);
    end
    reset = 1'b1; wbop = 3'd0; alu = 32'h1234; rd = 5'd3; we = 1'b1;
    advance();
    n_checks++;
    if (w_data !== 32'h1234 || w_rd !== 5'd3 || w_we !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_first_capture: got data=%h rd=%0d we=%b, want 1234/3/1",
               w_data, w_rd, w_we);
    end
  endtask

  task automatic test_loads();
    logic [2:0]  lops [6] = '{3'd3, 3'd4, 3'd3, 3'd1, 3'd2, 3'd0};
    logic [1:0]  offs [6] = '{2'd2, 2'd3, 2'd0, 2'd2, 2'd0, 2'd0};
    logic [31:0] exps [6] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_0001,
                              32'hFFFF_80FF, 32'h0000_7F01, 32'h80FF_7F01};
    for (int k = 0; k < 6; k++) begin
      dm = 32'h80FF_7F01; wbop = 3'd1; ldop = lops[k];
      alu = {28'h1000_000, 2'b00, offs[k]}; rd = 5'd7; we = 1'b1;
      advance();
      n_checks++;
      if (w_data !== exps[k]) begin
        n_fail++;
        $display("FAIL load_directed[%0d]: got %h, want %h", k, w_data, exps[k]);
      end
    end
    repeat (40) begin
      randomize_m(); wbop = 3'd1;
      advance();
      n_checks++;
      if (w_data !== e_data || w_we !== e_we) begin
        n_fail++;
        $display("FAIL load_random: ldop=%0d off=%0d got %h/%b, want %h/%b",
                 ldop, alu[1:0], w_data, w_we, e_data, e_we);
      end
    end
  endtask

  task automatic test_sources();
    rd = 5'd9; we = 1'b1;
    wbop = 3'd3; pc = 32'h0000_3000; advance();
    n_checks++;
    if (w_data !== 32'h0000_3008) begin
      n_fail++; $display("FAIL pc_plus8: got %h, want 00003008", w_data);
    end
    pc = 32'hFFFF_FFFC; advance();
    n_checks++;
    if (w_data !== 32'h0000_0004) begin
      n_fail++; $display("FAIL pc_plus8_wrap: got %h, want 00000004", w_data);
    end
    wbop = 3'd2; imm = $urandom; advance();
    n_checks++;
    if (w_data !== e_data || w_we !== 1'b1) begin
      n_fail++; $display("FAIL src_imm: got %h/%b, want %h/1", w_data, w_we, e_data);
    end
    wbop = 3'd4; md = $urandom; advance();
    n_checks++;
    if (w_data !== e_data || w_we !== 1'b1) begin
      n_fail++; $display("FAIL src_md: got %h/%b, want %h/1", w_data, w_we, e_data);
    end
    wbop = 3'd6; alu = $urandom; advance();
    n_checks++;
    if (w_data !== 32'd0 || w_we !== 1'b0) begin
      n_fail++; $display("FAIL src_reserved: got %h/%b, want 0/0", w_data, w_we);
    end
  endtask

  task automatic test_zero_reg();
    rd = 5'd0; we = 1'b1; wbop = 3'd0; alu = 32'h55; advance();
    n_checks++;
    if (w_we !== 1'b0 || w_data !== 32'h55) begin
      n_fail++; $display("FAIL zero_reg: got we=%b data=%h, want 0/55", w_we, w_data);
    end
  endtask

  task automatic test_stall_flush();
    logic [31:0] a_pc, a_data;
    logic [4:0]  a_rd;
    logic        a_we;
    randomize_m(); wbop = 3'd0; rd = 5'd12; we = 1'b1;
    advance();
    a_pc = e_pc; a_data = e_data; a_rd = e_rd; a_we = e_we;
    en = 1'b0;
    for (int c = 0; c < 3; c++) begin
      randomize_m(); advance();
      n_checks++;
      if (w_pc !== a_pc || w_data !== a_data || w_rd !== a_rd || w_we !== a_we) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: got %h/%h/%0d/%b, want %h/%h/%0d/%b", c,
                 w_pc, w_data, w_rd, w_we, a_pc, a_data, a_rd, a_we);
      end
    end
    en = 1'b1; flush = 1'b1; randomize_m(); advance();
    n_checks++;
    if ({w_pc, w_data, w_rd, w_we} !== 70'd0) begin
      n_fail++;
      $display("FAIL flush_bubble: got %h/%h/%0d/%b, want all 0", w_pc, w_data, w_rd, w_we);
    end
    flush = 1'b0; randomize_m(); wbop = 3'd2; rd = 5'd20; we = 1'b1; advance();
    n_checks++;
    if (w_pc !== pc || w_data !== imm || w_rd !== 5'd20 || w_we !== 1'b1) begin
      n_fail++;
      $display("FAIL after_flush: got %h/%h/%0d/%b, want %h/%h/20/1",
               w_pc, w_data, w_rd, w_we, pc, imm);
    end
    en = 1'b0; flush = 1'b1; randomize_m(); advance();
    n_checks++;
    if ({w_pc, w_data, w_rd, w_we} !== 70'd0) begin
      n_fail++; $display("FAIL flush_during_stall: got %h/%b, want 0/0", w_data, w_we);
    end
    flush = 1'b0; en = 1'b1;
  endtask

  task automatic test_random();
    repeat (300) begin
      randomize_m();
      reset = ($urandom_range(0, 24) != 0);
      en    = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 9) == 0);
      advance();
      n_checks++;
      if (w_pc !== e_pc || w_data !== e_data || w_rd !== e_rd || w_we !== e_we) begin
        n_fail++;
        $display("FAIL random: got %h/%h/%0d/%b, want %h/%h/%0d/%b",
                 w_pc, w_data, w_rd, w_we, e_pc, e_data, e_rd, e_we);
      end
    end
    reset = 1'b1; en = 1'b1; flush = 1'b0;
  endtask

  task automatic test_wide();
    logic [63:0] exp;
    wbop64 = 3'd1; ldop64 = 3'd3; alu64 = 64'h100; dm64 = 64'hDEAD_BEEF_0000_0080;
    pc64 = 64'h0; imm64 = 64'h0; md64 = 64'h0; rd64 = 5'd4; we64 = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (w_data64 !== 64'hFFFF_FFFF_FFFF_FF80 || w_we64 !== 1'b1) begin
      n_fail++; $display("FAIL wide_lb: got %h/%b, want ffffffffffffff80/1", w_data64, w_we64);
    end
    wbop64 = 3'd3; pc64 = 64'hFFFF_FFFF_FFFF_FFFC;
    @(posedge clk); #1;
    n_checks++;
    if (w_data64 !== 64'h4) begin
      n_fail++; $display("FAIL wide_pc_wrap: got %h, want 4", w_data64);
    end
    repeat (20) begin
      pc64 = {$urandom, $urandom}; alu64 = {$urandom, $urandom}; dm64 = {$urandom, $urandom};
      imm64 = {$urandom, $urandom}; md64 = {$urandom, $urandom};
      wbop64 = 3'($urandom_range(0, 7)); ldop64 = 3'($urandom_range(1, 4));
      exp = ref_data(64, wbop64, ldop64, pc64, alu64, dm64, imm64, md64);
      @(posedge clk); #1;
      n_checks++;
      if (w_data64 !== exp) begin
        n_fail++;
        $display("FAIL wide_random: op=%0d ld=%0d got %h, want %h", wbop64, ldop64, w_data64, exp);
      end
    end
  endtask

  initial begin
    reset = 1'b0; en = 1'b0; flush = 1'b0;
    pc = '0; alu = '0; dm = '0; imm = '0; md = '0; wbop = '0; ldop = '0; rd = '0; we = 1'b0;
    pc64 = '0; alu64 = '0; dm64 = '0; imm64 = '0; md64 = '0;
    wbop64 = '0; ldop64 = '0; rd64 = '0; we64 = 1'b0;
    e_pc = '0; e_data = '0; e_rd = '0; e_we = 1'b0;
    #2;
    test_reset();
    test_loads();
    test_sources();
    test_zero_reg();
    test_stall_flush();
    test_random();
    test_wide();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
